// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the two-digit seven-segment multiplexer.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        SHOW_ONES = 2'd0,
        GAP_A     = 2'd1,
        SHOW_TENS = 2'd2,
        GAP_B     = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder, {g,f,e,d,c,b,a}; non-BCD values show a dash.
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0: seg_c = 7'h3F;
            4'd1: seg_c = 7'h06;
            4'd2: seg_c = 7'h5B;
            4'd3: seg_c = 7'h4F;
            4'd4: seg_c = 7'h66;
            4'd5: seg_c = 7'h6D;
            4'd6: seg_c = 7'h7D;
            4'd7: seg_c = 7'h07;
            4'd8: seg_c = 7'h7F;
            4'd9: seg_c = 7'h6F;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps and per-frame input latch.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 1000,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    output logic [6:0] seg_o,
    output logic [1:0] dig_o,
    output logic       frame_o
);

    localparam int unsigned   MAX_DIV   = max_u(REFRESH_DIV, GAP_CYCLES);
    localparam int unsigned   CNT_W     = $clog2(MAX_DIV);
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [6:0]    BLANK_OUT = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tens_q, ones_q, tens_d, ones_d;
    logic             latch_c;
    logic [3:0]       sel_digit;
    logic [6:0]       dec_seg, seg_raw, seg_d;
    logic [1:0]       dig_d;

    // State and phase counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= GAP_B;
            cnt_q   <= GAP_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance when the counter expires, reloading for the new state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        latch_c = 1'b0;
        if (cnt_q == '0) begin
            case (state_q)
                SHOW_ONES: begin
                    state_d = GAP_A;
                    cnt_d   = GAP_LOAD;
                end
                GAP_A: begin
                    state_d = SHOW_TENS;
                    cnt_d   = SHOW_LOAD;
                end
                SHOW_TENS: begin
                    state_d = GAP_B;
                    cnt_d   = GAP_LOAD;
                end
                GAP_B: begin
                    state_d = SHOW_ONES;
                    cnt_d   = SHOW_LOAD;
                    latch_c = 1'b1;
                end
                default: begin
                    state_d = GAP_B;
                    cnt_d   = GAP_LOAD;
                end
            endcase
        end
    end

    bcd_to_7seg u_dec (
        .digit (sel_digit),
        .seg_c (dec_seg)
    );

    // Outputs are computed from the next state so the registers align with the state edge
    always_comb begin
        tens_d    = latch_c ? tens_i : tens_q;
        ones_d    = latch_c ? ones_i : ones_q;
        sel_digit = (state_d == SHOW_TENS) ? tens_d : ones_d;
        seg_raw   = SEG_BLANK;
        dig_d     = DIG_NONE;
        case (state_d)
            SHOW_ONES: begin
                dig_d   = DIG_ONES;
                seg_raw = dec_seg;
            end
            SHOW_TENS: begin
                if (!(BLANK_LZ && (tens_d == 4'd0))) begin
                    dig_d   = DIG_TENS;
                    seg_raw = dec_seg;
                end
            end
            default: begin
                dig_d   = DIG_NONE;
                seg_raw = SEG_BLANK;
            end
        endcase
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    // Latched digits and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            seg_o   <= BLANK_OUT;
            dig_o   <= DIG_NONE;
            frame_o <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            seg_o   <= seg_d;
            dig_o   <= dig_d;
            frame_o <= latch_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench: three parameter variants driven in lockstep against a frame-arithmetic model.
module tb_seven_seg_mux;

    localparam int R = 4;
    localparam int G = 2;
    localparam int F = 2 * (R + G);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [1:0] dig_a, dig_b, dig_c;
    logic       frame_a, frame_b, frame_c;

    always #5 clk = ~clk;

    seven_seg_mux #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .tens_i(tens), .ones_i(ones),
        .seg_o(seg_a), .dig_o(dig_a), .frame_o(frame_a));

    seven_seg_mux #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .tens_i(tens), .ones_i(ones),
        .seg_o(seg_b), .dig_o(dig_b), .frame_o(frame_b));

    seven_seg_mux #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .tens_i(tens), .ones_i(ones),
        .seg_o(seg_c), .dig_o(dig_c), .frame_o(frame_c));

    typedef struct {
        logic [6:0] seg_a, seg_b, seg_c;
        logic [1:0] dig_a, dig_b, dig_c;
        logic       frame;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: edges since reset release and the digits captured at the last frame start
    int   edges = 0;
    int   lt = 0;
    int   lo = 0;

    function automatic logic [6:0] ref_seg(input int v);
        logic [6:0] tbl [0:9];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (v >= 0 && v <= 9) ? tbl[v] : 7'h40;
    endfunction

    function automatic bit in_tens();
        int ph;
        if (edges < G) return 1'b0;
        ph = (edges - G) % F;
        return (ph >= R + G) && (ph < 2 * R + G);
    endfunction

    task automatic model_step(output exp_t e);
        int ph;
        e.seg_a = 7'h00; e.seg_b = 7'h00; e.seg_c = 7'h7F;
        e.dig_a = 2'b00; e.dig_b = 2'b00; e.dig_c = 2'b00;
        e.frame = 1'b0;
        if (rst) begin
            edges = 0; lt = 0; lo = 0;
            return;
        end
        edges++;
        if (edges < G) return;
        ph = (edges - G) % F;
        if (ph == 0) begin
            lt = int'(tens); lo = int'(ones);
            e.frame = 1'b1;
        end
        if (ph < R) begin
            e.dig_a = 2'b01; e.dig_b = 2'b01; e.dig_c = 2'b01;
            e.seg_a = ref_seg(lo); e.seg_b = ref_seg(lo); e.seg_c = ~ref_seg(lo);
        end else if (ph >= R + G && ph < 2 * R + G) begin
            e.dig_b = 2'b10; e.seg_b = ref_seg(lt);
            if (lt != 0) begin
                e.dig_a = 2'b10; e.dig_c = 2'b10;
                e.seg_a = ref_seg(lt); e.seg_c = ~ref_seg(lt);
            end
        end
    endtask

    task automatic drive(input int n, input logic r, input logic [3:0] t, input logic [3:0] o,
                         input bit rnd);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rnd) begin
                rst  = ($urandom_range(0, 39) == 0);
                tens = 4'($urandom_range(0, 15));
                ones = 4'($urandom_range(0, 15));
            end else begin
                rst = r; tens = t; ones = o;
            end
            model_step(e);
            q.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: one expected record per clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg_a", {1'b0, seg_a}, {1'b0, e.seg_a});
            chk("dig_a", {6'd0, dig_a}, {6'd0, e.dig_a});
            chk("frame_a", {7'd0, frame_a}, {7'd0, e.frame});
            chk("seg_nolz", {1'b0, seg_b}, {1'b0, e.seg_b});
            chk("dig_nolz", {6'd0, dig_b}, {6'd0, e.dig_b});
            chk("frame_nolz", {7'd0, frame_b}, {7'd0, e.frame});
            chk("seg_lowact", {1'b0, seg_c}, {1'b0, e.seg_c});
            chk("dig_lowact", {6'd0, dig_c}, {6'd0, e.dig_c});
            chk("frame_lowact", {7'd0, frame_c}, {7'd0, e.frame});
            chk("dig_not_both", {7'd0, (dig_a == 2'b11) || (dig_c == 2'b11)}, 8'd0);
        end
    end

    initial begin
        drive(3, 1'b1, 4'd4, 4'd2, 1'b0);
        drive(26, 1'b0, 4'd4, 4'd2, 1'b0);
        drive(14, 1'b0, 4'd7, 4'd3, 1'b0);
        drive(14, 1'b0, 4'd9, 4'd9, 1'b0);
        drive(26, 1'b0, 4'd0, 4'd5, 1'b0);
        drive(26, 1'b0, 4'd12, 4'd15, 1'b0);
        for (int k = 0; k < F && !in_tens(); k++) drive(1, 1'b0, 4'd4, 4'd2, 1'b0);
        drive(2, 1'b1, 4'd4, 4'd2, 1'b0);
        drive(30, 1'b0, 4'd4, 4'd2, 1'b0);
        drive(400, 1'b0, 4'd0, 4'd0, 1'b1);
        drive(3, 1'b1, 4'd0, 4'd0, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Time-multiplexed two-digit seven-segment driver for the scoreboard display path. It sits directly downstream of the binary-to-decimal converter and consumes its `tens_o`/`ones_o` BCD digits. It alternates the two digits on a shared segment bus, inserting a blanking gap between digits to suppress ghosting. Input digits are latched once per frame so a digit pair never tears mid-frame.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles each digit is lit; must be ≥ 2.
- `GAP_CYCLES`, default 8: clock cycles of blanking after each digit; must be ≥ 1.
- `BLANK_LZ`, default 1: 1 means a tens digit of 0 is blanked.
- `SEG_ACTIVE_LOW`, default 0: 1 means `seg_o` is inverted at the output.

Ports:
- `clk_i` input, 1 bit: single clock for the whole block.
- `rst_i` input, 1 bit: reset; synchronous, active-high.
- `tens_i` input, 4 bits: BCD tens digit from the converter.
- `ones_i` input, 4 bits: BCD ones digit from the converter.
- `seg_o` output, 7 bits: segment pattern in the order {g,f,e,d,c,b,a}, with `a` in bit 0.
- `dig_o` output, 2 bits: one-hot digit enable, active-high; bit 0 is ones, bit 1 is tens.
- `frame_o` output, 1 bit: single-cycle pulse on the edge where inputs are latched.

## Operation
- The FSM has four states, cycling SHOW_ONES → GAP_A → SHOW_TENS → GAP_B → SHOW_ONES.
- A single down-counter times each state:
  - SHOW states last `REFRESH_DIV` cycles.
  - GAP states last `GAP_CYCLES` cycles.
  - The counter reloads on every state change.
- Input latch:
  - `tens_q` and `ones_q` load from `tens_i`/`ones_i` only on the GAP_B → SHOW_ONES transition edge.
  - `frame_o` is 1 for exactly that cycle.
  - Input changes at any other time are invisible until the next frame.
- Decode (per digit value):
  - Values 0–9 use the standard patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Values 10–15 show a dash, 0x40.
- Per-state output:
  - SHOW_ONES: `dig_o`=2'b01, `seg_o`=decode(`ones_q`).
  - SHOW_TENS: `dig_o`=2'b10, `seg_o`=decode(`tens_q`).
  - Leading-zero blanking: if `BLANK_LZ`=1 and `tens_q`=0 in SHOW_TENS, then `dig_o`=2'b00 and segments are blank.
  - GAP_A and GAP_B: `dig_o`=2'b00, segments blank.
- Blank means 0x00 before polarity. `SEG_ACTIVE_LOW`=1 inverts all seven `seg_o` bits, so blank drives 0x7F. `dig_o` is never inverted.

## Timing
- Reset values: state=GAP_B, counter=`GAP_CYCLES`-1, `tens_q`=`ones_q`=0, `dig_o`=2'b00, `seg_o`=blank (0x00, or 0x7F when active-low), `frame_o`=0.
- After `rst_i` falls, the first latch and `frame_o` pulse occur on the `GAP_CYCLES`-th rising edge.
- `seg_o`, `dig_o` and `frame_o` are registers. They change on the same edge as the state register, with zero added latency.
- Frame length is exactly 2·(`REFRESH_DIV`+`GAP_CYCLES`) cycles, constant.
- `dig_o` is never 2'b11. Two different digits are never enabled on consecutive cycles; at least `GAP_CYCLES` blank cycles separate them.
- Reset asserted mid-frame forces reset values on the next edge, whatever the state or count.
- Reset has priority over everything.
- An input change on the latch edge itself: the value present at that edge is captured.
- Counter width is $clog2(max(`REFRESH_DIV`,`GAP_CYCLES`)). It wraps only by reload, never by overflow.

## Structure
- Shared package `seven_seg_pkg` holds:
  - the state enum (SHOW_ONES, GAP_A, SHOW_TENS, GAP_B);
  - constants SEG_BLANK=7'h00 and SEG_DASH=7'h40;
  - the digit-enable constants.
- Sub-module `bcd_to_7seg` is purely combinational: 4-bit in, 7-bit out, dash for values above 9. It is instantiated once, fed by a mux of `ones_q`/`tens_q`.
- FSM, counter, latch and output registers all live in `seven_seg_mux`.

## Test plan
Unless stated otherwise, runs use `REFRESH_DIV`=4, `GAP_CYCLES`=2, `BLANK_LZ`=1, `SEG_ACTIVE_LOW`=0.

- **Reset and first frame:** hold `rst_i` for 3 cycles with inputs 4/2.
  - During reset: `seg_o`=0x00, `dig_o`=00.
  - 2 cycles after release: `frame_o` pulses, then `dig_o`=01 with `seg_o`=0x5B for 4 cycles, 00 for 2, 10 with 0x66 for 4, 00 for 2.
- **Mid-frame input change:** inputs 7/3, change to 9/9 during SHOW_TENS.
  - The current frame still shows 0x4F / 0x07.
  - The next frame shows 0x6F / 0x6F.
  - Frame period stays 12 cycles.
- **Leading zero:** inputs 0/5.
  - SHOW_ONES shows 0x6D.
  - SHOW_TENS has `dig_o`=00 and `seg_o`=0x00.
  - Repeat with `BLANK_LZ`=0: tens shows 0x3F with `dig_o`=10.
- **Invalid BCD:** inputs 12/15 → both digits show 0x40.
- **Polarity:** `SEG_ACTIVE_LOW`=1, inputs 4/2.
  - Ones shows 0x24 and tens shows 0x19.
  - Gaps show 0x7F.
  - `dig_o` is unchanged from the active-high run.
- **Reset mid-operation:** assert `rst_i` during SHOW_TENS.
  - The next edge gives `dig_o`=00 and blank `seg_o`.
  - After release, the first `frame_o` pulse arrives after exactly 2 cycles.
  - Throughout the run, `dig_o` is never 11.
